fifo_stream_reader: RTL

//  Read-side drain engine for the async FIFO, clocked in the read domain.

---
 rtl/fifo_stream_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-domain drain engine: pops the async FIFO into a 2-entry output buffer feeding a
// valid/ready stream, with a discard-all flush sequence and an accepted-beat counter.
module fifo_stream_reader #(
   parameter int DATASIZE = 8,
   parameter int CNTSIZE  = 16
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic                en,
   input  logic                flush,
   input  logic                fifo_empty,
   input  logic [DATASIZE-1:0] fifo_rdata,
   output logic                fifo_rinc,
   output logic [DATASIZE-1:0] m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                busy,
   output logic [CNTSIZE-1:0]  word_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [1:0]          buf_cnt_r;
   logic [1:0]          buf_cnt_nxt_s;
   logic [DATASIZE-1:0] buf0_r;
   logic [DATASIZE-1:0] buf1_r;
   logic [DATASIZE-1:0] buf0_nxt_s;
   logic [DATASIZE-1:0] buf1_nxt_s;
   logic                m_valid_r;
   logic                busy_r;
   logic [CNTSIZE-1:0]  word_count_r;
   logic                fifo_rinc_s;
   logic                push_s;
   logic                accept_s;

   // m_valid is registered, so the accept term never feeds back into the pop strobe.
   assign accept_s   = m_valid_r && m_ready;
   assign push_s     = fifo_rinc_s && (state_r == ST_RUN);
   assign fifo_rinc  = fifo_rinc_s;
   assign m_data     = buf0_r;
   assign m_valid    = m_valid_r;
   assign busy       = busy_r;
   assign word_count = word_count_r;

   // Pop strobe decoded only from registered state, buffer occupancy and fifo_empty.
   always_comb begin
      fifo_rinc_s = 1'b0;
      case (state_r)
         ST_RUN:   fifo_rinc_s = !fifo_empty && (buf_cnt_r < 2'd2);
         ST_FLUSH: fifo_rinc_s = !fifo_empty;
         default:  fifo_rinc_s = 1'b0;
      endcase
   end

   // Next-state logic; flush overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = ST_FLUSH;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (en) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (en) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_FLUSH: begin
               if (!fifo_empty) begin
                  state_nxt_s = ST_FLUSH;
               end else if (en) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Output buffer update: buf0 is the head; a push lands behind whatever survives the accept.
   always_comb begin
      buf_cnt_nxt_s = buf_cnt_r;
      buf0_nxt_s    = buf0_r;
      buf1_nxt_s    = buf1_r;
      if (flush) begin
         buf_cnt_nxt_s = 2'd0;
      end else begin
         case ({push_s, accept_s})
            2'b01: begin
               buf0_nxt_s    = buf1_r;
               buf_cnt_nxt_s = buf_cnt_r - 2'd1;
            end
            2'b10: begin
               if (buf_cnt_r == 2'd0) begin
                  buf0_nxt_s = fifo_rdata;
               end else begin
                  buf1_nxt_s = fifo_rdata;
               end
               buf_cnt_nxt_s = buf_cnt_r + 2'd1;
            end
            2'b11: begin
               if (buf_cnt_r == 2'd1) begin
                  buf0_nxt_s = fifo_rdata;
               end else begin
                  buf0_nxt_s = buf1_r;
                  buf1_nxt_s = fifo_rdata;
               end
            end
            default: buf_cnt_nxt_s = buf_cnt_r;
         endcase
      end
   end

   // State, buffer and registered output flops.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state_r      <= ST_IDLE;
         buf_cnt_r    <= 2'd0;
         buf0_r       <= {DATASIZE{1'b0}};
         buf1_r       <= {DATASIZE{1'b0}};
         m_valid_r    <= 1'b0;
         busy_r       <= 1'b0;
         word_count_r <= {CNTSIZE{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         buf_cnt_r    <= buf_cnt_nxt_s;
         buf0_r       <= buf0_nxt_s;
         buf1_r       <= buf1_nxt_s;
         m_valid_r    <= (buf_cnt_nxt_s != 2'd0) && (state_nxt_s != ST_FLUSH);
         busy_r       <= (state_nxt_s == ST_FLUSH);
         word_count_r <= word_count_r + {{(CNTSIZE-1){1'b0}}, accept_s};
      end
   end

endmodule
